// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard sequencer: load-use bubbles, data-memory wait freeze and taken-branch flush.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    input  logic [REG_ADDR_W-1:0] ifid_rs,
    input  logic [REG_ADDR_W-1:0] ifid_rt,
    input  logic                  ifid_uses_rs,
    input  logic                  ifid_uses_rt,
    input  logic                  branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  stall_choose,
    output logic                  ifid_flush,
    output logic                  pipe_freeze,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      lu_stall_cnt,
    output logic [CNT_W-1:0]      mem_wait_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} stateT;

    localparam logic        MULTI_BUBBLE = (LOAD_STALL_CYCLES > 1);
    localparam logic [2:0]  LU_RELOAD    = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_AT   = 16'(MEM_TIMEOUT);

    stateT       state;
    logic [2:0]  luCnt;
    logic [15:0] waitCnt;
    logic [15:0] waitCntNext;
    logic        retLu;
    logic        timeoutFlag;
    logic        hazard;
    logic        memWait;
    logic        frozen;
    logic        luPending;

    // Hazard / wait detection and the "pipeline must freeze or bubble" decisions
    always_comb begin
        hazard  = idex_memread && (idex_rt != {REG_ADDR_W{1'b0}}) &&
                  ((ifid_uses_rs && (ifid_rs == idex_rt)) || (ifid_uses_rt && (ifid_rt == idex_rt)));
        memWait = dmem_req && !dmem_ready;
        if (state == MEM_WAIT) begin
            frozen      = !dmem_ready;
            waitCntNext = (waitCnt == 16'hFFFF) ? waitCnt : waitCnt + 16'd1;
        end else begin
            frozen      = memWait;
            waitCntNext = 16'd1;
        end
        // A wait that interrupted a load-use stall resumes the remaining bubbles on the ready cycle
        luPending = (state == LU_STALL) || ((state == MEM_WAIT) && retLu && (luCnt != 3'd0));
    end

    // Mealy output decode: reset > freeze > bubble > branch flush
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        stall_choose = 1'b0;
        ifid_flush   = 1'b0;
        pipe_freeze  = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            stall_choose = 1'b1;
            ifid_flush   = 1'b1;
        end else if (frozen) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (luPending || hazard) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            stall_choose = 1'b1;
        end else begin
            ifid_flush = branch_taken;
        end
    end

    // Sequencer state, bubble/wait counters and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            luCnt       <= 3'd0;
            waitCnt     <= 16'd0;
            retLu       <= 1'b0;
            timeoutFlag <= 1'b0;
        end else if (frozen) begin
            state   <= MEM_WAIT;
            waitCnt <= waitCntNext;
            if (state != MEM_WAIT) begin
                retLu <= (state == LU_STALL);
            end else begin
                retLu <= retLu;
            end
            if (waitCntNext == TIMEOUT_AT) begin
                timeoutFlag <= 1'b1;
            end else begin
                timeoutFlag <= timeoutFlag;
            end
        end else if (luPending) begin
            retLu <= 1'b0;
            luCnt <= (luCnt != 3'd0) ? luCnt - 3'd1 : 3'd0;
            state <= (luCnt > 3'd1) ? LU_STALL : RUN;
        end else if (hazard && MULTI_BUBBLE) begin
            retLu <= 1'b0;
            luCnt <= LU_RELOAD;
            state <= LU_STALL;
        end else begin
            retLu <= 1'b0;
            state <= RUN;
        end
    end

    assign mem_timeout = timeoutFlag;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] luStallCnt;
    logic [CNT_W-1:0] memWaitCnt;
    logic [CNT_W-1:0] flushCnt;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Saturating event counters driven by the decoded outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            luStallCnt <= {CNT_W{1'b0}};
            memWaitCnt <= {CNT_W{1'b0}};
            flushCnt   <= {CNT_W{1'b0}};
        end else begin
            luStallCnt <= stall_choose ? satInc(luStallCnt) : luStallCnt;
            memWaitCnt <= pipe_freeze  ? satInc(memWaitCnt) : memWaitCnt;
            flushCnt   <= ifid_flush   ? satInc(flushCnt)   : flushCnt;
        end
    end

    assign lu_stall_cnt = luStallCnt;
    assign mem_wait_cnt = memWaitCnt;
    assign flush_cnt    = flushCnt;
`else
    assign lu_stall_cnt = {CNT_W{1'b0}};
    assign mem_wait_cnt = {CNT_W{1'b0}};
    assign flush_cnt    = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven bench for hazard_stall_ctrl: dutA (2 bubbles, timeout 3), dutB (3 bubbles).
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, idexMemread, ifidUsesRs, ifidUsesRt, branchTaken, dmemReq, dmemReady;
    logic [4:0] idexRt, ifidRs, ifidRt;

    logic        aPc, aIfw, aStall, aFlush, aFreeze, aTmo;
    logic [31:0] aLuCnt, aMwCnt, aFlCnt;
    logic        bPc, bIfw, bStall, bFlush, bFreeze, bTmo;
    logic [31:0] bLuCnt, bMwCnt, bFlCnt;

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(3), .CNT_W(32)) dutA (
        .clk(clk), .rst_n(rst_n), .idex_memread(idexMemread), .idex_rt(idexRt),
        .ifid_rs(ifidRs), .ifid_rt(ifidRt), .ifid_uses_rs(ifidUsesRs), .ifid_uses_rt(ifidUsesRt),
        .branch_taken(branchTaken), .dmem_req(dmemReq), .dmem_ready(dmemReady),
        .pc_write(aPc), .ifid_write(aIfw), .stall_choose(aStall), .ifid_flush(aFlush),
        .pipe_freeze(aFreeze), .mem_timeout(aTmo),
        .lu_stall_cnt(aLuCnt), .mem_wait_cnt(aMwCnt), .flush_cnt(aFlCnt)
    );

    hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(3), .CNT_W(32)) dutB (
        .clk(clk), .rst_n(rst_n), .idex_memread(idexMemread), .idex_rt(idexRt),
        .ifid_rs(ifidRs), .ifid_rt(ifidRt), .ifid_uses_rs(ifidUsesRs), .ifid_uses_rt(ifidUsesRt),
        .branch_taken(branchTaken), .dmem_req(dmemReq), .dmem_ready(dmemReady),
        .pc_write(bPc), .ifid_write(bIfw), .stall_choose(bStall), .ifid_flush(bFlush),
        .pipe_freeze(bFreeze), .mem_timeout(bTmo),
        .lu_stall_cnt(bLuCnt), .mem_wait_cnt(bMwCnt), .flush_cnt(bFlCnt)
    );

    // exp = {pc_write, ifid_write, stall_choose, ifid_flush, pipe_freeze, mem_timeout}
    typedef struct {
        logic       rstn;
        logic       mr;
        logic [4:0] idexRt;
        logic [4:0] rs;
        logic       ur;
        logic [4:0] rt;
        logic       ut;
        logic       br;
        logic       req;
        logic       rdy;
        logic [5:0] exp;
    } vecT;

    vecT vecsA[$];
    vecT vecsB[$];
    int  nTests = 0;
    int  nFail  = 0;
    logic [31:0] expLu = 32'd0;
    logic [31:0] expMw = 32'd0;
    logic [31:0] expFl = 32'd0;

    function automatic vecT mk(input logic rstn, input logic mr, input logic [4:0] irt,
                               input logic [4:0] rs, input logic ur, input logic [4:0] rt,
                               input logic ut, input logic br, input logic req, input logic rdy,
                               input logic [5:0] exp);
        vecT v;
        v.rstn = rstn; v.mr = mr; v.idexRt = irt; v.rs = rs; v.ur = ur; v.rt = rt;
        v.ut = ut; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyVec(input vecT v, input bit useB, input string name);
        rst_n = v.rstn; idexMemread = v.mr; idexRt = v.idexRt; ifidRs = v.rs; ifidUsesRs = v.ur;
        ifidRt = v.rt; ifidUsesRt = v.ut; branchTaken = v.br; dmemReq = v.req; dmemReady = v.rdy;
        @(negedge clk);
        if (useB) begin
            check(name, {bPc, bIfw, bStall, bFlush, bFreeze, bTmo}, v.exp);
        end else begin
            check(name, {aPc, aIfw, aStall, aFlush, aFreeze, aTmo}, v.exp);
            check({name, " cnt"}, {aLuCnt, aMwCnt, aFlCnt}, {expLu, expMw, expFl});
        end
        @(posedge clk);
        #1;
        if (!useB) begin
            if (!v.rstn) begin
                expLu = 32'd0; expMw = 32'd0; expFl = 32'd0;
            end else begin
`ifdef HAZARD_PERF_CNT_EN
                expLu = expLu + {31'd0, v.exp[3]};
                expMw = expMw + {31'd0, v.exp[1]};
                expFl = expFl + {31'd0, v.exp[2]};
`endif
            end
        end
    endtask

    initial begin
        //              rstn  mr    irt    rs     ur    rt     ut    br    req   rdy   exp
        vecsA.push_back(mk(1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b001100)); // reset
        vecsA.push_back(mk(1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b110000)); // idle
        vecsA.push_back(mk(1'b1, 1'b1, 5'd8,  5'd8,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 6'b001000)); // lu rs #1
        vecsA.push_back(mk(1'b1, 1'b1, 5'd8,  5'd8,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 6'b001000)); // lu rs #2
        vecsA.push_back(mk(1'b1, 1'b0, 5'd8,  5'd8,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 6'b110000)); // resume
        vecsA.push_back(mk(1'b1, 1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 6'b110000)); // rt=$0
        vecsA.push_back(mk(1'b1, 1'b1, 5'd9,  5'd2,  1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 6'b110000)); // rt unused
        vecsA.push_back(mk(1'b1, 1'b1, 5'd9,  5'd9,  1'b0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 6'b110000)); // rs unused
        vecsA.push_back(mk(1'b1, 1'b1, 5'd12, 5'd1,  1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001000)); // lu rt + br
        vecsA.push_back(mk(1'b1, 1'b0, 5'd12, 5'd1,  1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001000)); // stall + br
        vecsA.push_back(mk(1'b1, 1'b0, 5'd12, 5'd1,  1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 6'b110100)); // flush
        vecsA.push_back(mk(1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b110000));
        vecsA.push_back(mk(1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'b000010)); // wait 1
        vecsA.push_back(mk(1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'b000010)); // wait 2
        vecsA.push_back(mk(1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'b000010)); // wait 3
        vecsA.push_back(mk(1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 6'b110101)); // ready+br
        vecsA.push_back(mk(1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b110001)); // sticky
        vecsA.push_back(mk(1'b1, 1'b1, 5'd5,  5'd5,  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'b000011)); // wait>lu
        vecsA.push_back(mk(1'b1, 1'b1, 5'd5,  5'd5,  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 6'b001001)); // ready, lu
        vecsA.push_back(mk(1'b0, 1'b1, 5'd5,  5'd5,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b001101)); // rst stall
        vecsA.push_back(mk(1'b1, 1'b0, 5'd5,  5'd5,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b110000)); // back RUN
        vecsA.push_back(mk(1'b1, 1'b1, 5'd4,  5'd5,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 6'b110000)); // no match
        vecsA.push_back(mk(1'b1, 1'b0, 5'd7,  5'd7,  1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 6'b110000)); // not load

        // dutB: wait arrives in the 2nd LU_STALL cycle, then a plain 3-bubble load-use
        vecsB.push_back(mk(1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b001100));
        vecsB.push_back(mk(1'b1, 1'b1, 5'd7,  5'd7,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b001000));
        vecsB.push_back(mk(1'b1, 1'b1, 5'd7,  5'd7,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b001000));
        vecsB.push_back(mk(1'b1, 1'b1, 5'd7,  5'd7,  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'b000010));
        vecsB.push_back(mk(1'b1, 1'b1, 5'd7,  5'd7,  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'b000010));
        vecsB.push_back(mk(1'b1, 1'b1, 5'd7,  5'd7,  1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 6'b001000));
        vecsB.push_back(mk(1'b1, 1'b0, 5'd7,  5'd7,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'b110000));
        vecsB.push_back(mk(1'b1, 1'b1, 5'd3,  5'd0,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 6'b001000));
        vecsB.push_back(mk(1'b1, 1'b1, 5'd3,  5'd0,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 6'b001000));
        vecsB.push_back(mk(1'b1, 1'b1, 5'd3,  5'd0,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 6'b001000));
        vecsB.push_back(mk(1'b1, 1'b0, 5'd3,  5'd0,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 6'b110000));

        rst_n = 1'b0; idexMemread = 1'b0; idexRt = 5'd0; ifidRs = 5'd0; ifidRt = 5'd0;
        ifidUsesRs = 1'b0; ifidUsesRt = 1'b0; branchTaken = 1'b0; dmemReq = 1'b0; dmemReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecsA.size(); i++) begin
            applyVec(vecsA[i], 1'b0, $sformatf("A%0d", i));
        end
        for (int j = 0; j < vecsB.size(); j++) begin
            applyVec(vecsB[j], 1'b1, $sformatf("B%0d", j));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard sequencer for the 5-stage MIPS core. It sits in ID, detects load-use hazards, waits on the data memory and handles taken-branch flushes. It drives the PC/IF-ID write enables, the bubble-select line of the ID-stage control mux, the IF/ID flush and a global pipeline freeze. It holds a small FSM for multi-cycle load-use stalls and memory-wait timeout, plus optional performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5, register specifier width
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with forwarding, 2 without); legal range 1..7
- MEM_TIMEOUT, 255, memory-wait cycles before `mem_timeout` is raised; legal range 1..65535
- CNT_W, 32, performance counter width

Ports (one clock, `clk`; reset `rst_n` is synchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- idex_memread  in  1  instruction in EX is a load
- idex_rt  in  REG_ADDR_W  load destination register in EX
- ifid_rs, ifid_rt  in  REG_ADDR_W  source specifiers of the instruction in ID
- ifid_uses_rs, ifid_uses_rt  in  1  ID instruction actually reads rs / rt
- branch_taken  in  1  ID-stage branch resolved taken
- dmem_req  in  1  MEM-stage access (read or write) active
- dmem_ready  in  1  data memory completes this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register write enable
- stall_choose  out  1  1 = zero the control word into ID/EX (bubble)
- ifid_flush  out  1  clear IF/ID to a NOP
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- mem_timeout  out  1  sticky error flag
- lu_stall_cnt, mem_wait_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- hazard = idex_memread & (idex_rt != 0) & ((ifid_uses_rs & ifid_rs == idex_rt) | (ifid_uses_rt & ifid_rt == idex_rt)).
- memwait = dmem_req & ~dmem_ready.
- Outputs are Mealy (state + current inputs). Priority: memwait > load-use > branch flush.
- Default in RUN with no event: pc_write = 1, ifid_write = 1, all other outputs 0.
- States: RUN, LU_STALL, MEM_WAIT. A 3-bit bubble counter `lu_cnt` and a 16-bit wait counter `wait_cnt` support them.

Per-state behaviour:
- RUN, memwait:
  - pipe_freeze = 1, pc_write = 0, ifid_write = 0, stall_choose = 0.
  - Next state is MEM_WAIT; wait_cnt is set to 1.
- RUN, hazard:
  - pc_write = 0, ifid_write = 0, stall_choose = 1. branch_taken is ignored; the branch re-resolves after the stall.
  - If LOAD_STALL_CYCLES > 1, go to LU_STALL with lu_cnt = LOAD_STALL_CYCLES - 1.
- RUN, branch_taken: ifid_flush = 1 for that cycle.
- LU_STALL: same outputs as a RUN hazard. lu_cnt decrements each cycle; at lu_cnt == 1 the next state is RUN.
- MEM_WAIT:
  - pipe_freeze = ~dmem_ready; pc_write and ifid_write are 0 while frozen.
  - On dmem_ready the outputs evaluate exactly as in RUN that cycle, and the next state is RUN.
  - wait_cnt increments and saturates at 65535. When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset.
- memwait during LU_STALL: freeze outputs take over and lu_cnt holds. The FSM enters MEM_WAIT and returns to LU_STALL (not RUN) when lu_cnt ≠ 0. A 1-bit return flag records this.
- Reset (rst_n = 0 at a clock edge): state = RUN, lu_cnt = 0, wait_cnt = 0, mem_timeout = 0, counters = 0.
  - While rst_n = 0, outputs are forced to: pc_write = 0, ifid_write = 0, stall_choose = 1, ifid_flush = 1, pipe_freeze = 0.
  - Reset asserted mid-stall or mid-wait aborts it immediately.

## Timing
- Zero-cycle latency: detection and outputs are combinational in the same cycle the hazard or wait is visible.
- Load-use costs exactly LOAD_STALL_CYCLES cycles, with stall_choose high for each of them.
- Memory wait holds the pipeline for exactly the cycles with dmem_ready = 0.
- mem_timeout rises on the clock edge at which wait_cnt reaches MEM_TIMEOUT.
- State, counters and flags update on the rising edge of clk only.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - lu_stall_cnt increments on every cycle with stall_choose = 1.
  - mem_wait_cnt increments on every cycle with pipe_freeze = 1.
  - flush_cnt increments on every cycle with ifid_flush = 1.
  - All three saturate at 2^CNT_W - 1 and clear on reset.
- HAZARD_PERF_CNT_EN undefined: the counter ports remain present but are tied to 0 and no counter flops exist.

## Test plan
- Load-use on rs: lw to $8 in EX (idex_memread = 1, idex_rt = 8); ID add reads rs = 8 with uses_rs = 1; LOAD_STALL_CYCLES = 2 -> pc_write/ifid_write = 0 and stall_choose = 1 for exactly 2 cycles, then pc_write = 1.
- False hazards: idex_rt = 0, or a matching rt with uses_rt = 0 -> no stall; pc_write = 1 every cycle.
- Branch vs hazard: branch_taken = 1 with a hazard -> ifid_flush = 0, stall_choose = 1. Next cycle, branch_taken = 1 with no hazard -> ifid_flush = 1 for 1 cycle; flush_cnt = 1 with macro on.
- Memory wait: dmem_req = 1, dmem_ready low for 3 cycles -> pipe_freeze high for 3 cycles and low on the ready cycle. With MEM_TIMEOUT = 3, mem_timeout = 1 and stays 1 until rst_n = 0.
- Wait during LU_STALL: LOAD_STALL_CYCLES = 3, memwait arrives in the 2nd stall cycle for 2 cycles -> freeze for 2 cycles, then 1 remaining bubble with stall_choose = 1, then RUN.
- Reset mid-stall: rst_n = 0 for 1 cycle during LU_STALL -> next cycle in RUN, all counters = 0, mem_timeout = 0.
